// File: rtl/alu_operand_stage_if.sv
// Operand handshake bundle between decode, the operand stage and the ALU.
// The stage takes the slave modport and the surrounding environment takes the master modport.
interface alu_operand_stage_if #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic [OP_WIDTH-1:0] in_op;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_a;
  logic [WIDTH-1:0]    out_b;
  logic [OP_WIDTH-1:0] out_op;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Two-entry skid buffer holding ALU operand sets between decode and the ALU.
// Define ALU_OP_CHECK_EN to drop sets carrying opcodes above 2 and raise a sticky error.
module alu_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_operand_stage_if.slave     bus,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic                   err_illegal_op
);

  localparam logic [OP_WIDTH-1:0] OP_MAX = OP_WIDTH'(2);

  logic                r_main_vld, r_skid_vld, r_in_ready, r_err;
  logic [WIDTH-1:0]    r_main_a, r_main_b, r_skid_a, r_skid_b;
  logic [OP_WIDTH-1:0] r_main_op, r_skid_op;
  logic [1:0]          r_occ;

  logic w_accept, w_xfer, w_illegal, w_store;
  logic w_main_vld_nx, w_skid_vld_nx;
  logic w_load_main_in, w_load_main_skid, w_load_skid;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_xfer   = r_main_vld && bus.out_ready;

`ifdef ALU_OP_CHECK_EN
  assign w_illegal = (bus.in_op > OP_MAX);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_store = w_accept && !w_illegal && !flush;

  // in_ready is registered as !skid_valid so out_ready never reaches it combinationally
  always_comb begin
    w_main_vld_nx    = r_main_vld;
    w_skid_vld_nx    = r_skid_vld;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_main_vld_nx = 1'b0;
      w_skid_vld_nx = 1'b0;
    end else if (r_skid_vld) begin
      if (w_xfer) begin
        w_load_main_skid = 1'b1;
        w_skid_vld_nx    = 1'b0;
      end
    end else if (w_store) begin
      if (!r_main_vld || w_xfer) begin
        w_load_main_in = 1'b1;
        w_main_vld_nx  = 1'b1;
      end else begin
        w_load_skid   = 1'b1;
        w_skid_vld_nx = 1'b1;
      end
    end else if (w_xfer) begin
      w_main_vld_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_in_ready <= 1'b0;
      r_err      <= 1'b0;
      r_occ      <= 2'd0;
      r_main_a   <= '0;
      r_main_b   <= '0;
      r_main_op  <= '0;
      r_skid_a   <= '0;
      r_skid_b   <= '0;
      r_skid_op  <= '0;
    end else begin
      r_main_vld <= w_main_vld_nx;
      r_skid_vld <= w_skid_vld_nx;
      r_in_ready <= !w_skid_vld_nx;
      r_occ      <= {1'b0, w_main_vld_nx} + {1'b0, w_skid_vld_nx};
      r_err      <= r_err | (w_accept && w_illegal);
      if (w_load_main_in) begin
        r_main_a  <= bus.in_a;
        r_main_b  <= bus.in_b;
        r_main_op <= bus.in_op;
      end else if (w_load_main_skid) begin
        r_main_a  <= r_skid_a;
        r_main_b  <= r_skid_b;
        r_main_op <= r_skid_op;
      end
      if (w_load_skid) begin
        r_skid_a  <= bus.in_a;
        r_skid_b  <= bus.in_b;
        r_skid_op <= bus.in_op;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_main_vld;
  assign bus.out_a       = r_main_a;
  assign bus.out_b       = r_main_b;
  assign bus.out_op      = r_main_op;
  assign occupancy       = r_occ;
  assign err_illegal_op  = r_err;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised bench for alu_operand_stage: FIFO-queue reference model plus literal spot checks.
module tb_alu_operand_stage;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  logic       err_illegal_op;

  alu_operand_stage_if #(.WIDTH(32), .OP_WIDTH(3)) ifc ();

  alu_operand_stage #(.WIDTH(32), .OP_WIDTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (ifc),
    .flush          (flush),
    .occupancy      (occupancy),
    .err_illegal_op (err_illegal_op)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  bit    chk_en = 1'b0;
  item_t q[$];
  bit    mod_rdy = 1'b0;
  bit    mod_err = 1'b0;
  bit    mod_inrst = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the stage is an order-preserving queue of at most two sets
  task automatic model_edge();
    bit xfer, acc, bad;
    item_t it;
    if (mod_inrst) return;
    xfer = (q.size() > 0) && ifc.out_ready;
    acc  = ifc.in_valid && mod_rdy;
`ifdef ALU_OP_CHECK_EN
    bad = acc && (ifc.in_op > 3'd2);
`else
    bad = 1'b0;
`endif
    if (bad) mod_err = 1'b1;
    if (xfer) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc && !bad) begin
      it.a = ifc.in_a; it.b = ifc.in_b; it.op = ifc.in_op;
      q.push_back(it);
    end
    mod_rdy = (q.size() < 2);
  endtask

  task automatic model_reset();
    q.delete();
    mod_rdy   = 1'b0;
    mod_err   = 1'b0;
    mod_inrst = 1'b1;
  endtask

  task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic ordy, input logic fl);
    @(negedge clk);
    ifc.in_valid  = iv;
    ifc.in_a      = a;
    ifc.in_b      = b;
    ifc.in_op     = op;
    ifc.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", ifc.out_valid, q.size() > 0);
      chk("occupancy", occupancy, q.size());
      chk("in_ready", ifc.in_ready, mod_rdy);
      chk("err_illegal_op", err_illegal_op, mod_err);
      if (q.size() > 0) begin
        chk("out_a", ifc.out_a, q[0].a);
        chk("out_b", ifc.out_b, q[0].b);
        chk("out_op", ifc.out_op, q[0].op);
      end else if (mod_inrst) begin
        chk("rst_out_a", ifc.out_a, 0);
        chk("rst_out_op", ifc.out_op, 0);
      end
    end
  end

  initial begin
    bit iv, ordy, fl;
    rst = 1'b1;
    flush = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_op = '0; ifc.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", ifc.out_valid, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_in_ready", ifc.in_ready, 0);
    chk("reset_err", err_illegal_op, 0);
    chk("reset_out_a", ifc.out_a, 0);
    chk_en = 1'b1;
    #1;
    rst = 1'b0;
    mod_inrst = 1'b0;

    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    chk("first_edge_in_ready", ifc.in_ready, 1);

    step(1'b1, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd1, 1'b1, 1'b0);
    chk("lat_out_valid", ifc.out_valid, 1);
    chk("lat_out_a", ifc.out_a, 32'hF0F0F0F0);
    chk("lat_out_b", ifc.out_b, 32'h0FF00FF0);
    chk("lat_out_op", ifc.out_op, 1);
    chk("lat_occupancy", occupancy, 1);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("drain_out_valid", ifc.out_valid, 0);

    step(1'b1, 32'h11111111, 32'h22222222, 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'h33333333, 32'h44444444, 3'd1, 1'b0, 1'b0);
    chk("skid_occupancy", occupancy, 2);
    chk("skid_in_ready", ifc.in_ready, 0);
    chk("skid_out_op", ifc.out_op, 0);
    step(1'b1, 32'h55555555, 32'h66666666, 3'd2, 1'b0, 1'b0);
    chk("stall_out_a", ifc.out_a, 32'h11111111);
    chk("stall_out_op", ifc.out_op, 0);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("order_out_op", ifc.out_op, 1);
    chk("order_out_a", ifc.out_a, 32'h33333333);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);
    chk("order_empty", ifc.out_valid, 0);

    step(1'b1, 32'hAAAA0001, 32'h1, 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0002, 32'h2, 3'd2, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA0003, 32'h3, 3'd1, 1'b0, 1'b1);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", ifc.out_valid, 0);
    chk("flush_in_ready", ifc.in_ready, 1);

    step(1'b1, 32'hBBBB0005, 32'h5, 3'd5, 1'b1, 1'b0);
`ifdef ALU_OP_CHECK_EN
    chk("illegal_dropped", ifc.out_valid, 0);
    chk("illegal_err", err_illegal_op, 1);
`else
    chk("illegal_passes", ifc.out_op, 5);
    chk("illegal_err_off", err_illegal_op, 0);
`endif
    step(1'b1, 32'hBBBB0002, 32'h2, 3'd2, 1'b1, 1'b0);
    chk("legal_out_op", ifc.out_op, 2);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

    void'($urandom(32'd20240611));
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      fl   = (i >= 100) && ($urandom_range(0, 31) == 0);
      step(iv, $urandom, $urandom, (i < 100) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
           ordy, fl);
    end

    step(1'b1, 32'hCCCC0001, 32'h1, 3'd0, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC0002, 32'h2, 3'd1, 1'b0, 1'b0);
    chk("pre_rst_occupancy", occupancy, 2);
    @(posedge clk);
    model_edge();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_out_valid", ifc.out_valid, 0);
    chk("async_rst_occupancy", occupancy, 0);
    chk("async_rst_in_ready", ifc.in_ready, 0);
    chk("async_rst_err", err_illegal_op, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mod_inrst = 1'b0;
    step(1'b1, 32'hDDDD0001, 32'h1, 3'd2, 1'b1, 1'b0);
    step(1'b1, 32'hDDDD0002, 32'h2, 3'd1, 1'b1, 1'b0);
    chk("post_rst_out_a", ifc.out_a, 32'hDDDD0002);
    step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter OP_WIDTH, default 3, ALU opcode width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream (decode) offers an operand set.
REQ-006 in_ready  output  1  stage accepts an operand set this cycle.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 in_op  input  OP_WIDTH  ALU opcode (0 = AND, 1 = OR, 2 = NOT A; others illegal).
REQ-010 flush  input  1  discard all held and incoming operand sets.
REQ-011 out_valid  output  1  operand set presented to ALU.
REQ-012 out_ready  input  1  ALU consumes the presented set this cycle.
REQ-013 out_a, out_b, out_op  output  WIDTH/WIDTH/OP_WIDTH  presented operand set.
REQ-014 occupancy  output  2  number of held entries, 0..2.
REQ-015 err_illegal_op  output  1  sticky illegal-opcode flag.

Function
REQ-016 The stage SHALL be a 2-entry skid buffer: a main register (drives out_*) and a skid register.
REQ-017 Accept SHALL occur when in_valid && in_ready; transfer SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-019 Accepted data SHALL go to main if main is empty or transfers in the same cycle; otherwise to skid.
REQ-020 On transfer with skid valid, skid contents SHALL move to main next cycle, preserving arrival order.
REQ-021 Simultaneous accept and transfer with skid valid is impossible (in_ready=0); with skid empty and main full, new data SHALL replace main, occupancy stays 1.
REQ-022 Latency SHALL be one cycle: data accepted at edge N is on out_* with out_valid=1 after edge N when main was empty.
REQ-023 out_a/out_b/out_op SHALL remain stable while out_valid && !out_ready.
REQ-024 occupancy SHALL equal main_valid + skid_valid, registered.
REQ-025 flush SHALL clear both valid bits at the next edge; data offered that cycle SHALL be dropped; a transfer in the flush cycle completes normally.
REQ-026 flush and accept in the same cycle SHALL leave occupancy 0.
REQ-027 No entry SHALL be lost or duplicated under any in_valid/out_ready pattern absent flush.

Reset
REQ-028 While rst=1: out_valid=0, occupancy=0, in_ready=0, err_illegal_op=0, out_a/out_b/out_op=0, skid register=0.
REQ-029 First rising clk edge after rst deasserts SHALL set in_ready=1.
REQ-030 Reset asserted mid-operation SHALL discard all held entries immediately without waiting for a clock.

Configuration
REQ-031 Macro ALU_OP_CHECK_EN SHALL gate opcode checking.
REQ-032 With ALU_OP_CHECK_EN defined: accepted sets with in_op > 2 SHALL be dropped (not stored) and err_illegal_op SHALL set and hold 1 until reset.
REQ-033 Without ALU_OP_CHECK_EN: all opcodes SHALL pass unchanged and err_illegal_op SHALL be constant 0.

Verification
REQ-034 Reset, then in_valid=1, a=0xF0F0F0F0, b=0x0FF00FF0, op=1, out_ready=1 -> next cycle out_valid=1, out_a=0xF0F0F0F0, out_op=1, occupancy=1.
REQ-035 out_ready=0, push sets op=0 then op=1 -> occupancy=2, in_ready=0, out_op=0 stable; raise out_ready -> out_op=0 then out_op=1 on successive cycles.
REQ-036 Streaming 16 sets with random out_ready (seed fixed) -> output sequence equals input sequence, no gaps or duplicates.
REQ-037 Occupancy 2, assert flush one cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1.
REQ-038 ALU_OP_CHECK_EN defined, push op=5 then op=2 -> only op=2 appears; err_illegal_op=1 until rst; undefined -> op=5 appears, err_illegal_op=0.
REQ-039 Assert rst asynchronously between edges with occupancy=2 -> out_valid=0 and occupancy=0 before next clk edge.
